// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: state codes, IR field
// values, datapath mux/ALU encodings, exception causes and the control bundle.
package multicycle_ctrl_pkg;

    typedef enum logic [4:0] {
        ST_RESET      = 5'd0,
        ST_FETCH      = 5'd1,
        ST_FETCH_WAIT = 5'd2,
        ST_IR_LOAD    = 5'd3,
        ST_DECODE     = 5'd4,
        ST_EXEC_R     = 5'd5,
        ST_WB_R       = 5'd6,
        ST_BRANCH     = 5'd7,
        ST_ADDR       = 5'd8,
        ST_LW_MEM     = 5'd9,
        ST_LW_WAIT    = 5'd10,
        ST_LW_WB      = 5'd11,
        ST_SW_MEM     = 5'd12,
        ST_SW_WAIT    = 5'd13,
        ST_LUI        = 5'd14,
        ST_JUMP       = 5'd15,
        ST_EXC        = 5'd16,
        ST_HALT       = 5'd17
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_NOP   = 6'h00;
    localparam logic [5:0] FN_BREAK = 6'h0D;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_XOR   = 6'h26;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_LUI  = 3'b101;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_EXC    = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b00;
    localparam logic [1:0] CAUSE_OVF     = 2'b01;

    localparam int unsigned WAIT_W = 4;

    typedef struct packed {
        logic       mem_wr;
        logic       iord;
        logic       ir_wr;
        logic       mdr_wr;
        logic       pc_wr;
        logic       pc_wr_cond;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       a_wr;
        logic       b_wr;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       aluout_wr;
        logic       reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_wr;
        logic       epc_wr;
        logic [1:0] cause;
        logic       halted;
    } ctrl_t;

    function automatic logic [2:0] funct_alu_op(input logic [5:0] funct);
        logic [2:0] op_v;
        case (funct)
            FN_ADD:  op_v = ALU_ADD;
            FN_SUB:  op_v = ALU_SUB;
            FN_AND:  op_v = ALU_AND;
            FN_XOR:  op_v = ALU_XOR;
            default: op_v = ALU_PASS;
        endcase
        return op_v;
    endfunction

    // Only the signed add/subtract trap on overflow; logic ops ignore the flag.
    function automatic logic funct_traps_ovf(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Memory wait-state down-counter shared by the fetch, load and store phases.
module mem_wait_counter
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = WAIT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_r;

    // Remaining wait cycles: load on a memory access, count down while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (srst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != '0)) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // A stray zero count also releases the wait so the FSM can never stall.
    assign done = (cnt_r <= CNT_W'(1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences every datapath enable and mux select,
// with memory wait states, LUI/J, EPC/cause exceptions and a sticky BREAK halt.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned STATE_W  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               overflow,
    output logic               mem_wr,
    output logic               iord,
    output logic               ir_wr,
    output logic               mdr_wr,
    output logic               pc_wr,
    output logic               pc_wr_cond,
    output logic               branch_ne,
    output logic [1:0]         pc_src,
    output logic               a_wr,
    output logic               b_wr,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic               aluout_wr,
    output logic               reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               reg_wr,
    output logic               epc_wr,
    output logic [1:0]         cause,
    output logic               halted,
    output logic [STATE_W-1:0] state_o
);

    localparam logic              NO_WAIT   = (MEM_WAIT == 32'd0);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_WAIT);

    state_t state_r;
    state_t next_state_s;
    ctrl_t  ctrl_r;
    ctrl_t  ctrl_next_s;
    logic   wait_load_s;
    logic   wait_dec_s;
    logic   wait_done_s;
    logic   wait_srst_s;

    assign wait_load_s = (state_r == ST_FETCH) || (state_r == ST_LW_MEM) || (state_r == ST_SW_MEM);
    assign wait_dec_s  = (state_r == ST_FETCH_WAIT) || (state_r == ST_LW_WAIT) || (state_r == ST_SW_WAIT);
    assign wait_srst_s = (state_r == ST_RESET);

    mem_wait_counter #(.CNT_W(WAIT_W)) u_wait (
        .clk      (clk),
        .rst_n    (reset),
        .srst     (wait_srst_s),
        .load     (wait_load_s),
        .dec      (wait_dec_s),
        .load_val (WAIT_LOAD),
        .done     (wait_done_s)
    );

    // Next-state selection, including instruction dispatch out of DECODE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_RESET:      next_state_s = ST_FETCH;
            ST_FETCH:      next_state_s = NO_WAIT ? ST_IR_LOAD : ST_FETCH_WAIT;
            ST_FETCH_WAIT: next_state_s = wait_done_s ? ST_IR_LOAD : ST_FETCH_WAIT;
            ST_IR_LOAD:    next_state_s = ST_DECODE;
            ST_DECODE: begin
                if (opcode == OP_RTYPE) begin
                    case (funct)
                        FN_ADD, FN_SUB, FN_AND, FN_XOR: next_state_s = ST_EXEC_R;
                        FN_BREAK:                       next_state_s = ST_HALT;
                        FN_NOP:                         next_state_s = ST_FETCH;
                        default:                        next_state_s = ST_EXC;
                    endcase
                end else begin
                    case (opcode)
                        OP_BEQ, OP_BNE: next_state_s = ST_BRANCH;
                        OP_LW, OP_SW:   next_state_s = ST_ADDR;
                        OP_LUI:         next_state_s = ST_LUI;
                        OP_J:           next_state_s = ST_JUMP;
                        default:        next_state_s = ST_EXC;
                    endcase
                end
            end
            ST_EXEC_R: begin
                if (overflow && funct_traps_ovf(funct)) begin
                    next_state_s = ST_EXC;
                end else begin
                    next_state_s = ST_WB_R;
                end
            end
            ST_WB_R:    next_state_s = ST_FETCH;
            ST_BRANCH:  next_state_s = ST_FETCH;
            ST_ADDR:    next_state_s = (opcode == OP_SW) ? ST_SW_MEM : ST_LW_MEM;
            ST_LW_MEM:  next_state_s = NO_WAIT ? ST_LW_WB : ST_LW_WAIT;
            ST_LW_WAIT: next_state_s = wait_done_s ? ST_LW_WB : ST_LW_WAIT;
            ST_LW_WB:   next_state_s = ST_FETCH;
            ST_SW_MEM:  next_state_s = NO_WAIT ? ST_FETCH : ST_SW_WAIT;
            ST_SW_WAIT: next_state_s = wait_done_s ? ST_FETCH : ST_SW_WAIT;
            ST_LUI:     next_state_s = ST_WB_R;
            ST_JUMP:    next_state_s = ST_FETCH;
            ST_EXC:     next_state_s = ST_FETCH;
            ST_HALT:    next_state_s = ST_HALT;
            default:    next_state_s = ST_RESET;
        endcase
    end

    // Control word for the state being entered, so outputs come straight from flops.
    always_comb begin
        ctrl_next_s = '0;
        case (next_state_s)
            ST_FETCH: begin
                ctrl_next_s.pc_wr     = 1'b1;
                ctrl_next_s.pc_src    = PC_SRC_ALU;
                ctrl_next_s.alu_src_b = SRCB_FOUR;
                ctrl_next_s.alu_op    = ALU_ADD;
            end
            ST_IR_LOAD: ctrl_next_s.ir_wr = 1'b1;
            ST_DECODE: begin
                ctrl_next_s.a_wr      = 1'b1;
                ctrl_next_s.b_wr      = 1'b1;
                ctrl_next_s.alu_src_b = SRCB_IMM_SH2;
                ctrl_next_s.alu_op    = ALU_ADD;
                ctrl_next_s.aluout_wr = 1'b1;
            end
            ST_EXEC_R: begin
                ctrl_next_s.alu_src_a = 1'b1;
                ctrl_next_s.alu_src_b = SRCB_B;
                ctrl_next_s.alu_op    = funct_alu_op(funct);
                ctrl_next_s.aluout_wr = 1'b1;
            end
            ST_WB_R: begin
                // LUI shares the ALUOut write-back but targets rt.
                ctrl_next_s.reg_dst    = (state_r != ST_LUI);
                ctrl_next_s.mem_to_reg = MTR_ALUOUT;
                ctrl_next_s.reg_wr     = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_next_s.alu_src_a  = 1'b1;
                ctrl_next_s.alu_src_b  = SRCB_B;
                ctrl_next_s.alu_op     = ALU_SUB;
                ctrl_next_s.pc_wr_cond = 1'b1;
                ctrl_next_s.pc_src     = PC_SRC_ALUOUT;
                ctrl_next_s.branch_ne  = opcode[0];
            end
            ST_ADDR: begin
                ctrl_next_s.alu_src_a = 1'b1;
                ctrl_next_s.alu_src_b = SRCB_IMM;
                ctrl_next_s.alu_op    = ALU_ADD;
                ctrl_next_s.aluout_wr = 1'b1;
            end
            ST_LW_MEM, ST_LW_WAIT: begin
                ctrl_next_s.iord   = 1'b1;
                ctrl_next_s.mdr_wr = 1'b1;
            end
            ST_LW_WB: begin
                ctrl_next_s.reg_dst    = 1'b0;
                ctrl_next_s.mem_to_reg = MTR_MDR;
                ctrl_next_s.reg_wr     = 1'b1;
            end
            ST_SW_MEM, ST_SW_WAIT: begin
                ctrl_next_s.iord   = 1'b1;
                ctrl_next_s.mem_wr = 1'b1;
            end
            ST_LUI: begin
                ctrl_next_s.alu_src_b = SRCB_IMM;
                ctrl_next_s.alu_op    = ALU_LUI;
                ctrl_next_s.aluout_wr = 1'b1;
            end
            ST_JUMP: begin
                ctrl_next_s.pc_wr  = 1'b1;
                ctrl_next_s.pc_src = PC_SRC_JUMP;
            end
            ST_EXC: begin
                ctrl_next_s.epc_wr = 1'b1;
                ctrl_next_s.pc_wr  = 1'b1;
                ctrl_next_s.pc_src = PC_SRC_EXC;
                ctrl_next_s.cause  = (state_r == ST_EXEC_R) ? CAUSE_OVF : CAUSE_ILLEGAL;
            end
            ST_HALT: ctrl_next_s.halted = 1'b1;
            default: ctrl_next_s = '0;
        endcase
    end

    // State and registered control word; reset clears both asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RESET;
            ctrl_r  <= '0;
        end else begin
            state_r <= next_state_s;
            ctrl_r  <= ctrl_next_s;
        end
    end

    assign mem_wr     = ctrl_r.mem_wr;
    assign iord       = ctrl_r.iord;
    assign ir_wr      = ctrl_r.ir_wr;
    assign mdr_wr     = ctrl_r.mdr_wr;
    assign pc_wr      = ctrl_r.pc_wr;
    assign pc_wr_cond = ctrl_r.pc_wr_cond;
    assign branch_ne  = ctrl_r.branch_ne;
    assign pc_src     = ctrl_r.pc_src;
    assign a_wr       = ctrl_r.a_wr;
    assign b_wr       = ctrl_r.b_wr;
    assign alu_src_a  = ctrl_r.alu_src_a;
    assign alu_src_b  = ctrl_r.alu_src_b;
    assign alu_op     = ctrl_r.alu_op;
    assign aluout_wr  = ctrl_r.aluout_wr;
    assign reg_dst    = ctrl_r.reg_dst;
    assign mem_to_reg = ctrl_r.mem_to_reg;
    assign reg_wr     = ctrl_r.reg_wr;
    assign epc_wr     = ctrl_r.epc_wr;
    assign cause      = ctrl_r.cause;
    assign halted     = ctrl_r.halted;
    assign state_o    = STATE_W'(state_r);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: four instances with MEM_WAIT = 0..3 share
// one instruction stream; a dispatch table plus multi-cycle corner sequences.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       overflow;

    logic       d_mem_wr [4];
    logic       d_iord [4];
    logic       d_ir_wr [4];
    logic       d_mdr_wr [4];
    logic       d_pc_wr [4];
    logic       d_pc_wr_cond [4];
    logic       d_branch_ne [4];
    logic [1:0] d_pc_src [4];
    logic       d_a_wr [4];
    logic       d_b_wr [4];
    logic       d_alu_src_a [4];
    logic [1:0] d_alu_src_b [4];
    logic [2:0] d_alu_op [4];
    logic       d_aluout_wr [4];
    logic       d_reg_dst [4];
    logic [1:0] d_mem_to_reg [4];
    logic       d_reg_wr [4];
    logic       d_epc_wr [4];
    logic [1:0] d_cause [4];
    logic       d_halted [4];
    logic [4:0] d_state [4];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        multicycle_ctrl #(.MEM_WAIT(g), .STATE_W(5)) u_dut (
            .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .overflow(overflow),
            .mem_wr(d_mem_wr[g]), .iord(d_iord[g]), .ir_wr(d_ir_wr[g]), .mdr_wr(d_mdr_wr[g]),
            .pc_wr(d_pc_wr[g]), .pc_wr_cond(d_pc_wr_cond[g]), .branch_ne(d_branch_ne[g]),
            .pc_src(d_pc_src[g]), .a_wr(d_a_wr[g]), .b_wr(d_b_wr[g]),
            .alu_src_a(d_alu_src_a[g]), .alu_src_b(d_alu_src_b[g]), .alu_op(d_alu_op[g]),
            .aluout_wr(d_aluout_wr[g]), .reg_dst(d_reg_dst[g]), .mem_to_reg(d_mem_to_reg[g]),
            .reg_wr(d_reg_wr[g]), .epc_wr(d_epc_wr[g]), .cause(d_cause[g]),
            .halted(d_halted[g]), .state_o(d_state[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_wr,pc_wr_cond,branch_ne}_{pc_src}_{alu_src_a}_{alu_src_b}_{alu_op}_{aluout_wr}_{epc_wr}_{cause}_{halted}
    function automatic logic [15:0] sig1(input int k);
        return {d_pc_wr[k], d_pc_wr_cond[k], d_branch_ne[k], d_pc_src[k], d_alu_src_a[k],
                d_alu_src_b[k], d_alu_op[k], d_aluout_wr[k], d_epc_wr[k], d_cause[k], d_halted[k]};
    endfunction

    // {reg_wr,reg_dst}_{mem_to_reg}_{mem_wr,iord,mdr_wr}_{epc_wr}_{cause}_{pc_wr}_{pc_src}
    function automatic logic [12:0] sig2(input int k);
        return {d_reg_wr[k], d_reg_dst[k], d_mem_to_reg[k], d_mem_wr[k], d_iord[k], d_mdr_wr[k],
                d_epc_wr[k], d_cause[k], d_pc_wr[k], d_pc_src[k]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset with the given IR fields, then release between clock edges.
    task automatic start_run(input logic [5:0] op, input logic [5:0] fn, input logic ovf);
        reset = 1'b0;
        opcode = op;
        funct = fn;
        overflow = ovf;
        step(2);
        reset = 1'b1;
    endtask

    task automatic wait_state(input int k, input state_t st, input int budget);
        int n = 0;
        while (d_state[k] !== st && n < budget) begin
            step(1);
            n++;
        end
        check($sformatf("wait_%s_w%0d", st.name(), k), 32'(d_state[k]), 32'(st));
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        ovf;
        state_t      s1;
        logic [15:0] g1;
        state_t      s2;
        logic [12:0] g2;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int first_ir0;
        int first_ir3;
        int n_rw;
        int n_exc;
        int n_h;
        int n_cnt;
        int n;
        logic seen;

        vecs[0]  = '{6'h00, 6'h20, 1'b0, ST_EXEC_R, 16'b000_00_1_00_001_1_0_00_0, ST_WB_R,  13'b11_00_000_0_00_0_00};
        vecs[1]  = '{6'h00, 6'h22, 1'b0, ST_EXEC_R, 16'b000_00_1_00_010_1_0_00_0, ST_WB_R,  13'b11_00_000_0_00_0_00};
        vecs[2]  = '{6'h00, 6'h24, 1'b1, ST_EXEC_R, 16'b000_00_1_00_011_1_0_00_0, ST_WB_R,  13'b11_00_000_0_00_0_00};
        vecs[3]  = '{6'h00, 6'h26, 1'b0, ST_EXEC_R, 16'b000_00_1_00_100_1_0_00_0, ST_WB_R,  13'b11_00_000_0_00_0_00};
        vecs[4]  = '{6'h00, 6'h20, 1'b1, ST_EXEC_R, 16'b000_00_1_00_001_1_0_00_0, ST_EXC,   13'b00_00_000_1_01_1_11};
        vecs[5]  = '{6'h00, 6'h22, 1'b1, ST_EXEC_R, 16'b000_00_1_00_010_1_0_00_0, ST_EXC,   13'b00_00_000_1_01_1_11};
        vecs[6]  = '{6'h00, 6'h00, 1'b0, ST_FETCH,  16'b100_00_0_01_001_0_0_00_0, ST_FETCH_WAIT, 13'b00_00_000_0_00_0_00};
        vecs[7]  = '{6'h00, 6'h0D, 1'b0, ST_HALT,   16'b000_00_0_00_000_0_0_00_1, ST_HALT,  13'b00_00_000_0_00_0_00};
        vecs[8]  = '{6'h00, 6'h21, 1'b0, ST_EXC,    16'b100_11_0_00_000_0_1_00_0, ST_FETCH, 13'b00_00_000_0_00_1_00};
        vecs[9]  = '{6'h04, 6'h0D, 1'b0, ST_BRANCH, 16'b010_01_1_00_010_0_0_00_0, ST_FETCH, 13'b00_00_000_0_00_1_00};
        vecs[10] = '{6'h05, 6'h20, 1'b1, ST_BRANCH, 16'b011_01_1_00_010_0_0_00_0, ST_FETCH, 13'b00_00_000_0_00_1_00};
        vecs[11] = '{6'h0F, 6'h20, 1'b0, ST_LUI,    16'b000_00_0_10_101_1_0_00_0, ST_WB_R,  13'b10_00_000_0_00_0_00};
        vecs[12] = '{6'h02, 6'h00, 1'b0, ST_JUMP,   16'b100_10_0_00_000_0_0_00_0, ST_FETCH, 13'b00_00_000_0_00_1_00};
        vecs[13] = '{6'h23, 6'h00, 1'b0, ST_ADDR,   16'b000_00_1_10_001_1_0_00_0, ST_LW_MEM, 13'b00_00_011_0_00_0_00};
        vecs[14] = '{6'h2B, 6'h00, 1'b0, ST_ADDR,   16'b000_00_1_10_001_1_0_00_0, ST_SW_MEM, 13'b00_00_110_0_00_0_00};
        vecs[15] = '{6'h3F, 6'h20, 1'b0, ST_EXC,    16'b100_11_0_00_000_0_1_00_0, ST_FETCH, 13'b00_00_000_0_00_1_00};

        reset = 1'b0;
        opcode = 6'h00;
        funct = 6'h00;
        overflow = 1'b0;
        step(1);
        check("reset_outputs", {sig1(1), sig2(1), d_a_wr[1], d_b_wr[1], d_ir_wr[1]}, 32'h0);
        check("reset_state", 32'(d_state[1]), 32'(ST_RESET));

        for (int i = 0; i < 16; i++) begin
            start_run(vecs[i].op, vecs[i].fn, vecs[i].ovf);
            wait_state(1, ST_DECODE, 20);
            step(1);
            check($sformatf("vec%0d_state1", i), 32'(d_state[1]), 32'(vecs[i].s1));
            check($sformatf("vec%0d_ctrl1", i), 32'(sig1(1)), 32'(vecs[i].g1));
            step(1);
            check($sformatf("vec%0d_state2", i), 32'(d_state[1]), 32'(vecs[i].s2));
            check($sformatf("vec%0d_ctrl2", i), 32'(sig2(1)), 32'(vecs[i].g2));
        end

        // ADD with one wait state: DECODE after 4 edges, WB_R after 6, FETCH after 7.
        start_run(6'h00, 6'h20, 1'b0);
        step(1);
        check("add_fetch", 32'(d_state[1]), 32'(ST_FETCH));
        step(3);
        check("add_decode", 32'(d_state[1]), 32'(ST_DECODE));
        check("add_decode_ctrl", 32'(sig1(1)), 32'(16'b000_00_0_11_001_1_0_00_0));
        check("add_decode_ab", 32'({d_a_wr[1], d_b_wr[1]}), 32'(2'b11));
        step(2);
        check("add_wb", 32'(d_state[1]), 32'(ST_WB_R));
        check("add_wb_regwr", 32'(d_reg_wr[1]), 32'(1'b1));
        step(1);
        check("add_refetch", 32'(d_state[1]), 32'(ST_FETCH));

        // ir_wr timing for zero and three wait states.
        start_run(6'h00, 6'h20, 1'b0);
        first_ir0 = -1;
        first_ir3 = -1;
        for (int c = 1; c <= 8; c++) begin
            step(1);
            if (d_ir_wr[0] && first_ir0 < 0) first_ir0 = c;
            if (d_ir_wr[3] && first_ir3 < 0) first_ir3 = c;
        end
        check("irwr_wait0", 32'(first_ir0), 32'd2);
        check("irwr_wait3", 32'(first_ir3), 32'd5);

        // SUB overflow: two exception entries in 12 edges, never a register write.
        start_run(6'h00, 6'h22, 1'b1);
        n_rw = 0;
        n_exc = 0;
        for (int c = 0; c < 12; c++) begin
            step(1);
            if (d_reg_wr[1]) n_rw++;
            if (d_epc_wr[1] && d_cause[1] == 2'b01 && d_pc_src[1] == 2'b11) n_exc++;
        end
        check("ovf_no_regwr", 32'(n_rw), 32'd0);
        check("ovf_exc_count", 32'(n_exc), 32'd2);

        // BREAK halts and stays halted until reset.
        start_run(6'h00, 6'h0D, 1'b0);
        wait_state(1, ST_HALT, 20);
        n_h = 0;
        for (int c = 0; c < 100; c++) begin
            step(1);
            if (d_halted[1] && d_state[1] == 5'(ST_HALT)) n_h++;
        end
        check("halt_held", 32'(n_h), 32'd100);
        reset = 1'b0;
        #1;
        check("halt_reset_halted", 32'(d_halted[1]), 32'd0);
        check("halt_reset_state", 32'(d_state[1]), 32'(ST_RESET));

        // LW with two wait states: mdr_wr for 3 cycles, then MDR write-back to rt.
        start_run(6'h23, 6'h00, 1'b0);
        n_cnt = 0;
        n = 0;
        while (!d_reg_wr[2] && n < 40) begin
            step(1);
            n++;
            if (d_mdr_wr[2]) n_cnt++;
        end
        check("lw_regwr", 32'(d_reg_wr[2]), 32'd1);
        check("lw_mdr_cycles", 32'(n_cnt), 32'd3);
        check("lw_wb_mux", 32'({d_mem_to_reg[2], d_reg_dst[2]}), 32'(3'b010));
        check("lw_wb_state", 32'(d_state[2]), 32'(ST_LW_WB));

        // SW with two wait states: mem_wr for exactly 3 cycles, then FETCH.
        start_run(6'h2B, 6'h00, 1'b0);
        n_cnt = 0;
        n = 0;
        seen = 1'b0;
        while (n < 40 && !(seen && d_state[2] == 5'(ST_FETCH))) begin
            step(1);
            n++;
            if (d_mem_wr[2]) begin
                n_cnt++;
                seen = 1'b1;
            end
        end
        check("sw_memwr_cycles", 32'(n_cnt), 32'd3);
        check("sw_done_state", 32'(d_state[2]), 32'(ST_FETCH));

        // Reset mid-store wait: mem_wr must fall before the next clock edge.
        start_run(6'h2B, 6'h00, 1'b0);
        wait_state(2, ST_SW_WAIT, 30);
        check("sw_wait_memwr", 32'(d_mem_wr[2]), 32'd1);
        reset = 1'b0;
        #1;
        check("sw_abort_memwr", 32'(d_mem_wr[2]), 32'd0);
        check("sw_abort_state", 32'(d_state[2]), 32'(ST_RESET));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
